// File: rtl/video_timing_rx.sv
// Video timing receiver: recovers pixel coordinates from an hs/vs/de stream,
// measures line/frame geometry and locks after consecutive matching frames.
module video_timing_rx #(
  parameter int H_DISP      = 1280,
  parameter int V_DISP      = 720,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        pixel_clk,
  input  logic        sys_rst,
  input  logic        video_hs,
  input  logic        video_vs,
  input  logic        video_de,
  input  logic [23:0] video_rgb,
  output logic        pixel_valid,
  output logic [23:0] pixel_data,
  output logic [10:0] pixel_xpos,
  output logic [10:0] pixel_ypos,
  output logic        frame_start,
  output logic        locked,
  output logic        fmt_err,
  output logic [10:0] meas_h_total,
  output logic [10:0] meas_v_total,
  output logic [10:0] meas_h_act,
  output logic [10:0] meas_v_act
);

  localparam logic [10:0] SAT = 11'd2047;

  typedef enum logic [1:0] {SEARCH, CHECK, LOCKED} state_t;
  state_t state;

  logic        hs_q, vs_q, de_q;
  logic        hs_fall, vs_fall, de_rise, de_fall;
  logic [10:0] h_cyc, line_period, line_cnt, x_cnt, y_cnt, act_w;
  logic [10:0] lp_next, w_next;
  logic [2:0]  good_cnt;
  logic        frame_bad, eval_bad, active;

  function automatic logic [10:0] sat_inc(input logic [10:0] v);
    return (v == SAT) ? SAT : v + 11'd1;
  endfunction

  assign hs_fall = hs_q & ~video_hs;
  assign vs_fall = vs_q & ~video_vs;
  assign de_rise = ~de_q & video_de;
  assign de_fall = de_q & ~video_de;
  assign lp_next = sat_inc(h_cyc);
  assign w_next  = sat_inc(x_cnt);
  assign active  = (state != SEARCH);

  // Frame verdict at vs_fall also covers a de-during-vsync seen on that very cycle.
  assign eval_bad = frame_bad | (y_cnt != 11'(V_DISP)) | (video_de & ~video_vs);

  assign pixel_xpos  = pixel_valid ? x_cnt : '0;
  assign pixel_ypos  = pixel_valid ? y_cnt : '0;
  assign frame_start = pixel_valid & (x_cnt == '0) & (y_cnt == '0);

  always_ff @(posedge pixel_clk) begin
    if (sys_rst) begin
      state        <= SEARCH;
      hs_q         <= 1'b0;
      vs_q         <= 1'b0;
      de_q         <= 1'b0;
      h_cyc        <= '0;
      line_period  <= '0;
      line_cnt     <= '0;
      x_cnt        <= '0;
      y_cnt        <= '0;
      act_w        <= '0;
      good_cnt     <= '0;
      frame_bad    <= 1'b0;
      pixel_valid  <= 1'b0;
      pixel_data   <= '0;
      locked       <= 1'b0;
      fmt_err      <= 1'b0;
      meas_h_total <= '0;
      meas_v_total <= '0;
      meas_h_act   <= '0;
      meas_v_act   <= '0;
    end else begin
      hs_q        <= video_hs;
      vs_q        <= video_vs;
      de_q        <= video_de;
      fmt_err     <= 1'b0;
      pixel_valid <= video_de & active;
      pixel_data  <= (video_de && active) ? video_rgb : '0;

      h_cyc <= hs_fall ? '0 : sat_inc(h_cyc);
      if (hs_fall) line_period <= lp_next;

      if (vs_fall)      line_cnt <= '0;
      else if (hs_fall) line_cnt <= sat_inc(line_cnt);

      if (de_rise)                x_cnt <= '0;
      else if (video_de && de_q)  x_cnt <= sat_inc(x_cnt);
      if (de_fall) act_w <= w_next;

      if (vs_fall)      y_cnt <= '0;
      else if (de_fall) y_cnt <= sat_inc(y_cnt);

      if (vs_fall)
        frame_bad <= 1'b0;
      else if ((de_fall && w_next != 11'(H_DISP)) || (video_de && !video_vs))
        frame_bad <= 1'b1;

      if (vs_fall) begin
        meas_h_total <= hs_fall ? lp_next : line_period;
        meas_v_total <= hs_fall ? sat_inc(line_cnt) : line_cnt;
        meas_h_act   <= act_w;
        meas_v_act   <= y_cnt;
        case (state)
          SEARCH: begin
            state    <= CHECK;
            good_cnt <= '0;
          end
          CHECK: begin
            if (eval_bad) begin
              fmt_err  <= 1'b1;
              good_cnt <= '0;
            end else begin
              good_cnt <= good_cnt + 3'd1;
              if (good_cnt + 3'd1 == 3'(LOCK_FRAMES)) begin
                state  <= LOCKED;
                locked <= 1'b1;
              end
            end
          end
          LOCKED: begin
            if (eval_bad) begin
              fmt_err  <= 1'b1;
              locked   <= 1'b0;
              state    <= CHECK;
              good_cnt <= '0;
            end
          end
          default: state <= SEARCH;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_video_timing_rx.sv
// Bench for video_timing_rx: a 24x12 timing stream (16x8 active) drives two
// instances (lock after 2 and after 1 good frame) checked cycle by cycle.
module tb_video_timing_rx;

  logic        pixel_clk = 1'b0;
  logic        sys_rst   = 1'b1;
  logic        video_hs  = 1'b1;
  logic        video_vs  = 1'b1;
  logic        video_de  = 1'b0;
  logic [23:0] video_rgb = '0;

  always #5 pixel_clk = ~pixel_clk;

  logic        pv_a, fs_a, lk_a, fe_a, pv_b, fs_b, lk_b, fe_b;
  logic [23:0] pd_a, pd_b;
  logic [10:0] px_a, py_a, px_b, py_b;
  logic [10:0] mht_a, mvt_a, mha_a, mva_a, mht_b, mvt_b, mha_b, mva_b;

  video_timing_rx #(.H_DISP(16), .V_DISP(8), .LOCK_FRAMES(2)) dut_a (
    .pixel_clk(pixel_clk), .sys_rst(sys_rst), .video_hs(video_hs), .video_vs(video_vs),
    .video_de(video_de), .video_rgb(video_rgb), .pixel_valid(pv_a), .pixel_data(pd_a),
    .pixel_xpos(px_a), .pixel_ypos(py_a), .frame_start(fs_a), .locked(lk_a), .fmt_err(fe_a),
    .meas_h_total(mht_a), .meas_v_total(mvt_a), .meas_h_act(mha_a), .meas_v_act(mva_a));

  video_timing_rx #(.H_DISP(16), .V_DISP(8), .LOCK_FRAMES(1)) dut_b (
    .pixel_clk(pixel_clk), .sys_rst(sys_rst), .video_hs(video_hs), .video_vs(video_vs),
    .video_de(video_de), .video_rgb(video_rgb), .pixel_valid(pv_b), .pixel_data(pd_b),
    .pixel_xpos(px_b), .pixel_ypos(py_b), .frame_start(fs_b), .locked(lk_b), .fmt_err(fe_b),
    .meas_h_total(mht_b), .meas_v_total(mvt_b), .meas_h_act(mha_b), .meas_v_act(mva_b));

  typedef struct packed {
    logic        v;
    logic [23:0] d;
    logic [10:0] x;
    logic [10:0] y;
    logic        fs;
    logic        lk;
    logic        fe;
  } obs_t;

  obs_t qa[$], qb[$];
  int   checks = 0, errors = 0;

  // Reference state, derived from what the bench itself has driven.
  bit armed = 0, fb = 0, m_vs_q = 0, lka = 0, lkb = 0;
  int ga = 0, gb = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic rst, input logic hs, input logic vs, input logic de,
                      input logic [23:0] rgb, input logic [10:0] ex, input logic [10:0] ey,
                      input logic bad);
    obs_t ea, eb, oa, ob;
    logic v, fe;
    @(negedge pixel_clk);
    if (qa.size() > 0) begin
      oa = {pv_a, pd_a, px_a, py_a, fs_a, lk_a, fe_a};
      ob = {pv_b, pd_b, px_b, py_b, fs_b, lk_b, fe_b};
      chk("pix_a", 64'(oa), 64'(qa.pop_front()));
      chk("pix_b", 64'(ob), 64'(qb.pop_front()));
    end
    sys_rst = rst; video_hs = hs; video_vs = vs; video_de = de; video_rgb = rgb;
    ea = '0;
    if (rst) begin
      armed = 0; fb = 0; m_vs_q = 0; lka = 0; lkb = 0; ga = 0; gb = 0;
    end else begin
      v = armed & de;
      fe = 1'b0;
      ea.v  = v;
      ea.d  = v ? rgb : '0;
      ea.x  = v ? ex : '0;
      ea.y  = v ? ey : '0;
      ea.fs = v && ex == 0 && ey == 0;
      if (m_vs_q && !vs) begin
        if (!armed) begin
          armed = 1; ga = 0; gb = 0;
        end else if (fb) begin
          fe = 1'b1; ga = 0; gb = 0; lka = 0; lkb = 0;
        end else begin
          ga++; gb++;
          if (ga >= 2) lka = 1;
          if (gb >= 1) lkb = 1;
        end
        fb = 0;
      end
      fb = fb | bad;
      m_vs_q = vs;
      ea.fe = fe;
    end
    eb = ea;
    ea.lk = lka;
    eb.lk = lkb;
    qa.push_back(ea);
    qb.push_back(eb);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 24'($urandom), '0, '0, 1'b0);
  endtask

  // mode 0 good, 1 last active line 15 wide, 2 de during vsync line, 3 reset mid-line
  task automatic frame(input int mode);
    int dl;
    logic de, bad, rst, any;
    dl = 0;
    for (int l = 0; l < 12; l++) begin
      any = 1'b0;
      for (int c = 0; c < 24; c++) begin
        de = (l >= 2 && l <= 9 && c >= 5 && c <= 20);
        bad = 1'b0;
        rst = 1'b0;
        if (mode == 1 && l == 9 && c == 20) begin de = 1'b0; bad = 1'b1; end
        if (mode == 2 && l == 0 && c >= 5 && c <= 20) begin de = 1'b1; bad = 1'b1; end
        if (mode == 3 && l == 5 && c == 10) rst = 1'b1;
        step(rst, c >= 2, l >= 1, de, 24'($urandom), 11'(c - 5), 11'(dl), bad);
        any = any | de;
      end
      if (any) dl++;
    end
  endtask

  initial begin
    step(1'b1, 1'b1, 1'b1, 1'b0, '0, '0, '0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0, '0, '0, '0, 1'b0);
    idle(5);
    chk("rst_meas_h_total", 64'(mht_a), 64'd0);
    chk("rst_meas_v_act", 64'(mva_a), 64'd0);

    frame(0);
    frame(0);
    chk("meas_h_total", 64'(mht_a), 64'd24);
    chk("meas_v_total", 64'(mvt_a), 64'd12);
    chk("meas_h_act", 64'(mha_a), 64'd16);
    chk("meas_v_act", 64'(mva_a), 64'd8);
    chk("lock1_b_early", 64'(lk_b), 64'd1);
    chk("lock2_a_not_yet", 64'(lk_a), 64'd0);
    frame(0);
    chk("lock2_a", 64'(lk_a), 64'd1);

    frame(1);
    chk("lock_held_short", 64'(lk_a), 64'd1);
    frame(0);
    chk("short_h_act", 64'(mha_a), 64'd15);
    chk("short_unlock", 64'(lk_a), 64'd0);
    frame(0);
    chk("relock_wait", 64'(lk_a), 64'd0);
    frame(0);
    chk("relock", 64'(lk_a), 64'd1);

    frame(2);
    frame(0);
    chk("vsde_unlock", 64'(lk_a), 64'd0);
    chk("vsde_v_act", 64'(mva_a), 64'd9);

    frame(3);
    chk("midrst_meas_h", 64'(mht_a), 64'd0);
    chk("midrst_meas_v", 64'(mvt_a), 64'd0);
    chk("midrst_lock_b", 64'(lk_b), 64'd0);
    frame(0);
    chk("rearm_lock_b", 64'(lk_b), 64'd0);
    frame(0);
    frame(0);
    chk("final_lock_a", 64'(lk_a), 64'd1);
    chk("final_h_total", 64'(mht_b), 64'd24);
    idle(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/video_timing_rx.md
# video_timing_rx

Receive-side counterpart of the display timing generator. It samples an incoming RGB888 video stream (hs/vs/de/rgb, sync active-low) and recovers per-pixel x/y coordinates and a frame-start marker for downstream processing such as the Sobel line buffers and frame writer. It also measures the incoming line and frame geometry and declares lock once consecutive frames match the expected active size.

## Interface
- H_DISP, 1280: expected active pixels per line
- V_DISP, 720: expected active lines per frame
- LOCK_FRAMES, 2: consecutive good frames required to assert `locked` (1..7)
- pixel_clk  in  1  pixel clock; all logic on rising edge
- sys_rst  in  1  reset; synchronous, active-high
- video_hs  in  1  line sync, active-low
- video_vs  in  1  frame sync, active-low
- video_de  in  1  active-video enable
- video_rgb  in  24  pixel data, valid when video_de=1
- pixel_valid  out  1  registered de, gated by state (see Operation)
- pixel_data  out  24  registered video_rgb; 0 when pixel_valid=0
- pixel_xpos  out  11  column of current pixel, 0-based
- pixel_ypos  out  11  active line of current pixel, 0-based
- frame_start  out  1  1-cycle pulse with pixel (0,0)
- locked  out  1  geometry stable and matching H_DISP x V_DISP
- fmt_err  out  1  1-cycle pulse when a checked frame fails
- meas_h_total  out  11  measured pixel_clk cycles per line
- meas_v_total  out  11  measured lines (hs falls) per frame
- meas_h_act  out  11  de-high width of last active line of frame
- meas_v_act  out  11  active line count of last frame

## Operation
- Previous-cycle copies hs_q, vs_q, de_q; edges: hs_fall = hs_q & ~video_hs, vs_fall = vs_q & ~video_vs, de_rise, de_fall likewise.
- h_cyc: 0 on hs_fall, else +1, saturating at 2047. On hs_fall, line_period <= h_cyc+1 (saturating).
- line_cnt: +1 per hs_fall; on vs_fall, meas_v_total <= line_cnt + hs_fall, line_cnt <= 0 (a coincident hs_fall closes the old frame).
- x_cnt: 0 on de_rise, +1 each further de-high cycle, saturating at 2047. On de_fall: act_w <= x_cnt+1; if act_w≠H_DISP set frame_bad.
- y_cnt: +1 on each de_fall, saturating; 0 on vs_fall.
- video_de=1 while video_vs=0 sets frame_bad.
- On vs_fall: meas_h_total <= line_period (including coincident hs_fall update), meas_h_act <= act_w, meas_v_act <= y_cnt; if y_cnt≠V_DISP, frame counts as bad; frame_bad cleared.
- States:
  - SEARCH (reset): pixel_valid held 0; vs_fall -> CHECK, good_cnt=0.
  - CHECK: each vs_fall evaluates the finished frame; good -> good_cnt+1, and reaching LOCK_FRAMES -> LOCKED; bad -> good_cnt=0, fmt_err pulse.
  - LOCKED: locked=1; vs_fall with bad frame -> fmt_err pulse, locked=0, CHECK, good_cnt=0.
- pixel_valid = video_de registered, only in CHECK/LOCKED.
- frame_start = pixel_valid & x=0 & y=0.
- xpos/ypos are 0 when pixel_valid=0.

## Timing
- Reset: all outputs 0, state SEARCH, all counters and meas registers 0.
- Latency: input sampled at edge n appears on pixel_* / frame_start at edge n+1 (one register stage).
- meas_* and locked update on the cycle after the vs_fall sample.
- fmt_err is a single cycle, concurrent with the meas_* update.
- Reset mid-frame: counters and outputs 0 next cycle. No pixel_valid until a vs_fall is seen.
- The first partial frame after SEARCH is never evaluated.
- Saturating counters never wrap. A 2047+ line fails the H_DISP check.

## Test plan
- 1280x720 stream (H 40/220/1280/110, V 5/20/720/5), 3 frames from reset:
  - locked rises after the 3rd vs_fall (2 good frames)
  - meas_h_total=1650, meas_v_total=750, meas_h_act=1280, meas_v_act=720
  - fmt_err never pulses
- Same stream, coordinates:
  - frame_start for exactly 1 cycle, 1 cycle after the first de sample of each frame
  - last pixel shows x=1279, y=719
  - pixel_data equals the input one cycle late; 0 when de=0
- While locked, one line with de high 1279 cycles:
  - next vs_fall -> fmt_err pulse, locked=0
  - locked re-asserts after 2 further good frames
- Assert sys_rst mid-line:
  - next cycle all outputs 0
  - pixel_valid stays 0 through the remaining partial frame, resumes after the next vs_fall
- de asserted during a vs-low line, otherwise valid frame -> fmt_err at next vs_fall, good_cnt restarts.
- H_DISP=16, V_DISP=8, LOCK_FRAMES=1, H/V totals 24x12:
  - locked after 1 good frame
  - meas_h_total=24, meas_v_total=12
  - x wraps 15->0 and y increments at each de_fall
